// File: rtl/exp_normalizer.sv
// rtl/exp_normalizer.sv - FP adder post-add normalizer, one-bit-per-cycle shifter.
// Define EXPNORM_LZC_EN to resolve NORM in one cycle with a leading-zero count.
module exp_normalizer #(
   parameter int EXP_W  = 5,
   parameter int FRAC_W = 10
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       in_Valid,
   output logic                       in_Ready,
   input  logic                       in_Sign,
   input  logic [EXP_W:1]             in_Exponent,
   input  logic [FRAC_W+2:1]          in_Mantissa_Sum,
   output logic                       out_Valid,
   input  logic                       out_Ready,
   output logic [EXP_W+FRAC_W+1:1]    out_Result,
   output logic                       out_Overflow,
   output logic                       out_Underflow
);
   localparam int MW = FRAC_W + 2;
   localparam logic [EXP_W+1:1] EXP_ONE = 1;
   localparam logic [EXP_W+1:1] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

   typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

   state_t           state, state_d;
   logic             sign_r, sign_d;
   logic [EXP_W:1]   exp_r, exp_d;
   logic [MW:1]      mant_r, mant_d;
   logic             ovf_r, ovf_d, unf_r, unf_d;
   logic [EXP_W+1:1] exp_inc;
`ifdef EXPNORM_LZC_EN
   int               lzc;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         sign_r <= 1'b0;
         exp_r  <= '0;
         mant_r <= '0;
         ovf_r  <= 1'b0;
         unf_r  <= 1'b0;
      end else begin
         state  <= state_d;
         sign_r <= sign_d;
         exp_r  <= exp_d;
         mant_r <= mant_d;
         ovf_r  <= ovf_d;
         unf_r  <= unf_d;
      end
   end

   always_comb begin
      state_d = state;
      sign_d  = sign_r;
      exp_d   = exp_r;
      mant_d  = mant_r;
      ovf_d   = ovf_r;
      unf_d   = unf_r;
      exp_inc = {1'b0, exp_r} + EXP_ONE;
`ifdef EXPNORM_LZC_EN
      // Distance of the leading one below the hidden position.
      lzc = 0;
      for (int i = 1; i <= MW - 1; i++) begin
         if (mant_r[i]) lzc = MW - 1 - i;
      end
`endif
      case (state)
         IDLE: begin
            if (in_Valid) begin
               sign_d  = in_Sign;
               exp_d   = in_Exponent;
               mant_d  = in_Mantissa_Sum;
               ovf_d   = 1'b0;
               unf_d   = 1'b0;
               state_d = NORM;
            end
         end
         NORM: begin
            if (mant_r == '0 || exp_r == '0) begin
               exp_d   = '0;
               mant_d  = '0;
               state_d = DONE;
            end else if (mant_r[MW]) begin
               state_d = DONE;
               if (exp_inc >= EXP_MAX) begin
                  exp_d  = '1;
                  mant_d = '0;
                  ovf_d  = 1'b1;
               end else begin
                  exp_d  = exp_inc[EXP_W:1];
                  mant_d = mant_r >> 1;
               end
            end else if (mant_r[MW-1]) begin
               state_d = DONE;
`ifdef EXPNORM_LZC_EN
            end else if (lzc >= int'(exp_r)) begin
               exp_d   = '0;
               mant_d  = '0;
               unf_d   = 1'b1;
               state_d = DONE;
            end else begin
               mant_d  = mant_r << lzc;
               exp_d   = exp_r - EXP_W'(lzc);
               state_d = DONE;
            end
`else
            end else if (exp_r == EXP_W'(1)) begin
               exp_d   = '0;
               mant_d  = '0;
               unf_d   = 1'b1;
               state_d = DONE;
            end else begin
               mant_d  = mant_r << 1;
               exp_d   = exp_r - EXP_W'(1);
            end
`endif
         end
         DONE: begin
            if (out_Ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_Ready      = (state == IDLE);
   assign out_Valid     = (state == DONE);
   assign out_Result    = {sign_r, exp_r, mant_r[FRAC_W:1]};
   assign out_Overflow  = ovf_r;
   assign out_Underflow = unf_r;
endmodule

// File: doc/exp_normalizer.md
# exp_normalizer

- Post-add normalization stage of the pipelined floating-point adder; it works in the opposite direction to exponent-difference alignment.
- Alignment shifts the smaller mantissa right by the exponent difference. This block takes the raw mantissa sum and the larger exponent and shifts left (or right on carry-out), adjusting the exponent each step.
- Output is a packed, normalized sign/exponent/fraction result.
- Iterative one-bit-per-cycle shifter with a valid/ready handshake on both sides.

## Interface
- EXP_W, 5, exponent width; bias-free unsigned; 0 encodes zero.
- FRAC_W, 10, stored fraction width (hidden bit not stored).
- clk  input  1  clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_Valid  input  1  operand present.
- in_Ready  output  1  block can accept; high only in IDLE.
- in_Sign  input  1  result sign, passed through unchanged.
- in_Exponent  input  [EXP_W:1]  larger operand exponent.
- in_Mantissa_Sum  input  [FRAC_W+2:1]  bit FRAC_W+2 = carry-out, FRAC_W+1 = hidden position, [FRAC_W:1] = fraction.
- out_Valid  output  1  result available.
- out_Ready  input  1  consumer accepts result.
- out_Result  output  [EXP_W+FRAC_W+1:1]  {sign, exponent, fraction}.
- out_Overflow  output  1  exponent saturated to all-ones.
- out_Underflow  output  1  result flushed to zero by exponent exhaustion.

## Operation
- States: IDLE, NORM, DONE.
- Reset: state IDLE; in_Ready=1; out_Valid=0; out_Result=0; both flags 0; internal mantissa and exponent registers 0.
- IDLE: if in_Valid, capture sign, exponent and mantissa; clear both flags; go to NORM.
- NORM, evaluated once per cycle, first matching rule wins:
  - Mantissa == 0, or exponent == 0: result is zero with exponent 0 and fraction 0; go to DONE. Sign is kept, and no flag is set.
  - Carry bit set: shift mantissa right 1 (truncate the dropped bit) and increment the exponent; go to DONE.
    - If the incremented exponent equals 2^EXP_W−1: fraction = 0, exponent = all-ones, out_Overflow = 1.
  - Hidden bit set: already normalized; go to DONE.
  - Otherwise, if exponent == 1: flush to zero (exponent 0, fraction 0), out_Underflow = 1; go to DONE.
  - Otherwise: shift mantissa left 1 and decrement the exponent; stay in NORM.
- DONE: out_Valid=1; out_Result and flags held stable. When out_Ready is high, go to IDLE the next edge.
- out_Result fraction = mantissa [FRAC_W:1]; hidden bit dropped.
- Rounding is truncation only.
- Arithmetic: exponent ± 1 is computed in EXP_W+1 bits; no wrap-around is ever permitted.

## Timing
- Input handshake: in_Valid & in_Ready at edge 0.
- Output handshake: out_Valid & out_Ready at the DONE edge.
- Latency, in cycles from the input handshake edge to the first out_Valid edge:
  - 2 for zero, carry, already-normalized or overflow cases.
  - k+2 for k left shifts.
  - Worst case FRAC_W+2.
- Throughput: one result per (latency+1) cycles minimum; there is no overlap between operations.
- in_Valid is ignored outside IDLE; the input need not be held after capture.
- out_Ready held high in DONE gives a one-cycle out_Valid pulse; out_Ready low stalls indefinitely.
- reset_n low at any time aborts the operation immediately; all outputs return to reset values asynchronously.

## Configuration
- EXPNORM_LZC_EN defined:
  - NORM resolves in a single cycle using a leading-zero count.
  - Left shift is by min(lzc, exponent−1) in one step. If lzc ≥ exponent, the result flushes to zero with out_Underflow=1.
  - Latency is always 2.
  - All other rules are unchanged.
- EXPNORM_LZC_EN undefined: iterative one-bit shifter as described above.
- Results and flags must be bit-identical in both builds; only latency differs.

## Test plan
- Reset mid-operation: assert reset_n low while in NORM -> in_Ready=1, out_Valid=0, out_Result=0 immediately.
- Carry: exp=5'd10, mant=12'b1_0_1000000000 -> result {s,5'd11,10'b0100000000}, out_Valid at cycle 2.
- Left shift: exp=5'd10, mant=12'b0_0_0010000000 (k=3) -> {s,5'd7,10'b0000000000}; out_Valid at cycle 5 (cycle 2 with EXPNORM_LZC_EN).
- Overflow: exp=5'd30, carry set -> exponent 5'd31, fraction 0, out_Overflow=1. Underflow: exp=5'd2, mant=12'b0_0_0000000001 -> zero result, out_Underflow=1.
- Zero sum: mant=0, exp=5'd9 -> out_Result = {s,15'b0}, no flags, latency 2. Hold out_Ready low 5 cycles -> out_Valid and out_Result stable, in_Ready=0 throughout.
